// File: rtl/uart_tx_frame_if.sv
// Parallel-to-serial handshake between the upstream FIFO/controller and the UART transmitter.
// The master drives the word and request strobe; the slave returns the serial line and BUSY.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output tx_out,
    output busy
  );

endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter clocked at the baud rate: start bit, LSB-first data, optional parity, stop bit.
// TX_OUT and BUSY come straight from flops, so every line bit lasts exactly one clock period.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [2:0]            state_n;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit_q;
  logic                  tx_n;
  logic                  accept;

  // A request is only taken from IDLE, which is exactly when BUSY is low.
  assign accept = (state == IDLE) && bus.data_valid;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (bus.data_valid) begin
          state_n = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = DATA;
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST_BIT) begin
          state_n = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        state_n = STOP;
      end
      STOP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // The line value is decoded from the next state so it lands on the same edge as the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_q[cnt_n];
      PARITY:  tx_n = par_bit_q;
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      bus.tx_out <= 1'b1;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bus.tx_out <= tx_n;
      bus.busy   <= (state_n != IDLE);
      if (accept) begin
        data_q    <= bus.p_data;
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
        par_bit_q <= (^bus.p_data) ^ bus.par_typ;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: each request pushes its expected line/BUSY trace,
// and every cycle after the active edge pops one entry and compares it with the DUT.
module tb_uart_tx_frame;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic exp_tx_q[$];
  logic exp_busy_q[$];

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected trace of one frame plus the single idle cycle that follows it.
  task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp);
    exp_tx_q.push_back(1'b0);
    exp_busy_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_tx_q.push_back(d[i]);
      exp_busy_q.push_back(1'b1);
    end
    if (pen) begin
      exp_tx_q.push_back((^d) ^ ptyp);
      exp_busy_q.push_back(1'b1);
    end
    exp_tx_q.push_back(1'b1);
    exp_busy_q.push_back(1'b1);
    exp_tx_q.push_back(1'b1);
    exp_busy_q.push_back(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d tx=%b busy=%b required tx=1 busy=0", c, bus.tx_out, bus.busy);
      end
    end
  endtask

  task automatic test_no_parity();
    logic e_tx;
    logic e_busy;
    int   busy_cnt;
    @(negedge clk);
    bus.p_data = 8'hA5;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    bus.data_valid = 1'b1;
    push_frame(8'hA5, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int c = 0; c < 40 && exp_tx_q.size() > 0; c++) begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      e_tx = exp_tx_q.pop_front();
      e_busy = exp_busy_q.pop_front();
      if (bus.busy === 1'b1) busy_cnt++;
      checks++;
      if (bus.tx_out !== e_tx || bus.busy !== e_busy) begin
        errors++;
        $display("[TB] FAIL nopar_bit cycle %0d tx=%b busy=%b required tx=%b busy=%b", c, bus.tx_out, bus.busy, e_tx, e_busy);
      end
    end
    checks++;
    if (busy_cnt != 10) begin
      errors++;
      $display("[TB] FAIL nopar_len busy cycles %0d required 10", busy_cnt);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d_tab[3]   = '{8'hB3, 8'hB3, 8'h00};
    logic       typ_tab[3] = '{1'b0, 1'b1, 1'b1};
    logic       par_tab[3] = '{1'b1, 1'b0, 1'b1};
    logic e_tx;
    logic e_busy;
    logic par_seen;
    int   busy_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.p_data = d_tab[k];
      bus.par_en = 1'b1;
      bus.par_typ = typ_tab[k];
      bus.data_valid = 1'b1;
      push_frame(d_tab[k], 1'b1, typ_tab[k]);
      busy_cnt = 0;
      par_seen = 1'bx;
      for (int c = 0; c < 40 && exp_tx_q.size() > 0; c++) begin
        @(negedge clk);
        bus.data_valid = 1'b0;
        e_tx = exp_tx_q.pop_front();
        e_busy = exp_busy_q.pop_front();
        if (bus.busy === 1'b1) busy_cnt++;
        if (c == 9) par_seen = bus.tx_out;
        checks++;
        if (bus.tx_out !== e_tx || bus.busy !== e_busy) begin
          errors++;
          $display("[TB] FAIL par_bit case %0d cycle %0d tx=%b busy=%b required tx=%b busy=%b", k, c, bus.tx_out, bus.busy, e_tx, e_busy);
        end
      end
      checks++;
      if (par_seen !== par_tab[k]) begin
        errors++;
        $display("[TB] FAIL par_value case %0d got %b required %b", k, par_seen, par_tab[k]);
      end
      checks++;
      if (busy_cnt != 11) begin
        errors++;
        $display("[TB] FAIL par_len case %0d busy cycles %0d required 11", k, busy_cnt);
      end
    end
  endtask

  task automatic test_busy_change();
    logic e_tx;
    logic e_busy;
    @(negedge clk);
    bus.p_data = 8'h0F;
    bus.par_en = 1'b1;
    bus.par_typ = 1'b0;
    bus.data_valid = 1'b1;
    push_frame(8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_tx_q.push_back(1'b1);
      exp_busy_q.push_back(1'b0);
    end
    for (int c = 0; c < 40 && exp_tx_q.size() > 0; c++) begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      if (c == 1) begin
        bus.p_data = 8'hFF;
        bus.par_en = 1'b0;
      end
      if (c == 3) bus.data_valid = 1'b1;
      e_tx = exp_tx_q.pop_front();
      e_busy = exp_busy_q.pop_front();
      checks++;
      if (bus.tx_out !== e_tx || bus.busy !== e_busy) begin
        errors++;
        $display("[TB] FAIL busy_ignore cycle %0d tx=%b busy=%b required tx=%b busy=%b", c, bus.tx_out, bus.busy, e_tx, e_busy);
      end
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic e_tx;
    logic e_busy;
    int   low_cnt;
    @(negedge clk);
    bus.p_data = 8'h55;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    bus.data_valid = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0);
    push_frame(8'hC3, 1'b0, 1'b0);
    low_cnt = 0;
    for (int c = 0; c < 60 && exp_tx_q.size() > 0; c++) begin
      @(negedge clk);
      if (c == 0) bus.p_data = 8'hC3;
      if (c == 11) bus.data_valid = 1'b0;
      if (c >= 1 && c <= 20 && bus.busy === 1'b0) low_cnt++;
      e_tx = exp_tx_q.pop_front();
      e_busy = exp_busy_q.pop_front();
      checks++;
      if (bus.tx_out !== e_tx || bus.busy !== e_busy) begin
        errors++;
        $display("[TB] FAIL b2b_bit cycle %0d tx=%b busy=%b required tx=%b busy=%b", c, bus.tx_out, bus.busy, e_tx, e_busy);
      end
    end
    bus.data_valid = 1'b0;
    checks++;
    if (low_cnt != 1) begin
      errors++;
      $display("[TB] FAIL b2b_gap busy-low cycles %0d required 1", low_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic e_tx;
    logic e_busy;
    logic hit;
    @(negedge clk);
    bus.p_data = 8'h81;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    bus.data_valid = 1'b1;
    push_frame(8'h81, 1'b0, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 40 && exp_tx_q.size() > 0 && !hit; c++) begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      e_tx = exp_tx_q.pop_front();
      e_busy = exp_busy_q.pop_front();
      checks++;
      if (bus.tx_out !== e_tx || bus.busy !== e_busy) begin
        errors++;
        $display("[TB] FAIL rstmid_pre cycle %0d tx=%b busy=%b required tx=%b busy=%b", c, bus.tx_out, bus.busy, e_tx, e_busy);
      end
      if (c == 4) begin
        rst = 1'b1;
        #2;
        checks++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rstmid_async tx=%b busy=%b required tx=1 busy=0", bus.tx_out, bus.busy);
        end
        hit = 1'b1;
      end
    end
    exp_tx_q.delete();
    exp_busy_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.p_data = 8'h3C;
    bus.data_valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0);
    for (int c = 0; c < 40 && exp_tx_q.size() > 0; c++) begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      e_tx = exp_tx_q.pop_front();
      e_busy = exp_busy_q.pop_front();
      checks++;
      if (bus.tx_out !== e_tx || bus.busy !== e_busy) begin
        errors++;
        $display("[TB] FAIL rstmid_post cycle %0d tx=%b busy=%b required tx=%b busy=%b", c, bus.tx_out, bus.busy, e_tx, e_busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.p_data = '0;
    bus.data_valid = 1'b0;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    test_reset();
    test_no_parity();
    test_parity();
    test_busy_change();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
